// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the PIC16C5x program-counter / return-stack slice:
// execute-Q4 operation encodings and the PCL register-file address.
package pc_stack_unit_pkg;

    localparam logic [2:0] PC_OP_NONE   = 3'd0;
    localparam logic [2:0] PC_OP_GOTO   = 3'd1;
    localparam logic [2:0] PC_OP_CALL   = 3'd2;
    localparam logic [2:0] PC_OP_RETLW  = 3'd3;
    localparam logic [2:0] PC_OP_PCLWR  = 3'd4;

    localparam logic [7:0] PC_PCL_ADDR  = 8'h02;

    // Operations that redirect fetch and therefore must suppress the next increment.
    function automatic logic isBranchOp(input logic [2:0] op);
        logic r;
        case (op)
            PC_OP_GOTO, PC_OP_CALL, PC_OP_RETLW: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular-shift hardware return stack: entry 0 is the top, the oldest entry
// falls off on overflow and the bottom entry is retained on pop.
module pc_return_stack #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [3:0]       level,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] entries [DEPTH];

    assign top = entries[0];

    // Entry shifting, saturating level count and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= {WIDTH{1'b0}};
            end
            level <= 4'd0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                entries[i] <= entries[i-1];
            end
            entries[0] <= din;
            if (level == 4'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                level <= level + 4'd1;
            end
        end else if (pop) begin
            // The bottom entry is deliberately left in place, matching silicon.
            for (int i = 0; i < DEPTH - 1; i++) begin
                entries[i] <= entries[i+1];
            end
            if (level == 4'd0) begin
                unf <= 1'b1;
            end else begin
                level <= level - 4'd1;
            end
        end else begin
            level <= level;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with STATUS page select, goto/skip flush flags and the
// hardware return stack for the PIC16C5x core.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int                PC_WIDTH     = 11,
    parameter int                STACK_DEPTH  = 2,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b1}},
    localparam int               PAGE_BITS    = PC_WIDTH - 9,
    localparam int               PSEL_W       = (PAGE_BITS > 0) ? PAGE_BITS : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fe_q1,
    input  logic                ex_q1,
    input  logic [2:0]          op,
    input  logic [8:0]          ir_addr,
    input  logic [7:0]          pcl_data,
    input  logic [PSEL_W-1:0]   page_sel,
    input  logic                skip_req,
    output logic [PC_WIDTH-1:0] pc,
    output logic                goto,
    output logic                skip,
    output logic [3:0]          stack_level,
    output logic                stack_ovf,
    output logic                stack_unf
);

    logic [PC_WIDTH-1:0] gotoTarget;
    logic [PC_WIDTH-1:0] callTarget;
    logic [PC_WIDTH-1:0] pclTarget;
    logic [PC_WIDTH-1:0] stackTop;
    logic [PC_WIDTH-1:0] pcNext;
    logic                gotoNext;
    logic                skipNext;
    logic                stackPush;
    logic                stackPop;

    // CALL and PCL writes can only reach the lower half of each page (bit 8 forced low).
    if (PAGE_BITS > 0) begin : gPaged
        assign gotoTarget = {page_sel, ir_addr};
        assign callTarget = {page_sel, 1'b0, ir_addr[7:0]};
        assign pclTarget  = {page_sel, 1'b0, pcl_data};
    end else begin : gFlat
        assign gotoTarget = ir_addr;
        assign callTarget = {1'b0, ir_addr[7:0]};
        assign pclTarget  = {1'b0, pcl_data};
    end

    // Operation decode: next PC, flag set/clear and stack control.
    always_comb begin
        pcNext    = pc;
        stackPush = 1'b0;
        stackPop  = 1'b0;
        case (op)
            PC_OP_GOTO:  pcNext = gotoTarget;
            PC_OP_CALL: begin
                pcNext    = callTarget;
                stackPush = 1'b1;
            end
            PC_OP_RETLW: begin
                pcNext   = stackTop;
                stackPop = 1'b1;
            end
            PC_OP_PCLWR: pcNext = pclTarget;
            default: begin
                if (fe_q1 && !goto) begin
                    pcNext = pc + PC_WIDTH'(1);
                end else begin
                    pcNext = pc;
                end
            end
        endcase

        if (isBranchOp(op)) begin
            gotoNext = 1'b1;
        end else if (ex_q1) begin
            gotoNext = 1'b0;
        end else begin
            gotoNext = goto;
        end

        if (isBranchOp(op) || (op == PC_OP_PCLWR) || skip_req) begin
            skipNext = 1'b1;
        end else if (ex_q1) begin
            skipNext = 1'b0;
        end else begin
            skipNext = skip;
        end
    end

    // PC and flush-flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc   <= RESET_VECTOR;
            goto <= 1'b0;
            skip <= 1'b0;
        end else begin
            pc   <= pcNext;
            goto <= gotoNext;
            skip <= skipNext;
        end
    end

    pc_return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) uStack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stackPush),
        .pop   (stackPop),
        .din   (pc),
        .top   (stackTop),
        .level (stack_level),
        .ovf   (stack_ovf),
        .unf   (stack_unf)
    );

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed test-plan scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_pc_stack_unit;

    localparam int PCW   = 11;
    localparam int DEPTH = 2;
    localparam int MASK  = (1 << PCW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           fe_q1 = 1'b0;
    logic           ex_q1 = 1'b0;
    logic [2:0]     op = 3'd0;
    logic [8:0]     ir_addr = 9'd0;
    logic [7:0]     pcl_data = 8'd0;
    logic [1:0]     page_sel = 2'd0;
    logic           skip_req = 1'b0;
    logic [PCW-1:0] pc;
    logic           goto;
    logic           skip;
    logic [3:0]     stack_level;
    logic           stack_ovf;
    logic           stack_unf;

    int total = 0;
    int bad = 0;
    bit chkEn = 1'b0;

    // Behavioural model state
    int mPc, mGoto, mSkip, mLvl, mOvf, mUnf;
    int q[$];

    pc_stack_unit #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .fe_q1(fe_q1), .ex_q1(ex_q1), .op(op),
        .ir_addr(ir_addr), .pcl_data(pcl_data), .page_sel(page_sel),
        .skip_req(skip_req), .pc(pc), .goto(goto), .skip(skip),
        .stack_level(stack_level), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one clock of the unit, computed from the rules with plain arithmetic.
    task automatic modelStep();
        int nPc, page, bot;
        bit setG, setS;
        page = int'(page_sel);
        nPc  = mPc;
        if (!rst_n) begin
            mPc = MASK; mGoto = 0; mSkip = 0; mLvl = 0; mOvf = 0; mUnf = 0;
            q.delete();
            for (int i = 0; i < DEPTH; i++) q.push_back(0);
            return;
        end
        setG = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
        setS = setG || (op == 3'd4) || skip_req;
        case (int'(op))
            1: nPc = page * 512 + int'(ir_addr);
            2: begin
                nPc = page * 512 + (int'(ir_addr) & 255);
                q.push_front(mPc);
                void'(q.pop_back());
                if (mLvl == DEPTH) mOvf = 1; else mLvl++;
            end
            3: begin
                nPc = q[0];
                bot = q[$];
                void'(q.pop_front());
                q.push_back(bot);
                if (mLvl == 0) mUnf = 1; else mLvl--;
            end
            4: nPc = page * 512 + int'(pcl_data);
            default: if (fe_q1 && mGoto == 0) nPc = (mPc + 1) & MASK;
        endcase
        mPc   = nPc;
        mGoto = setG ? 1 : (ex_q1 ? 0 : mGoto);
        mSkip = setS ? 1 : (ex_q1 ? 0 : mSkip);
    endtask

    task automatic step(input bit r, input bit fe, input bit ex, input int o,
                        input int ia, input int pd, input int ps, input bit sr);
        rst_n = r; fe_q1 = fe; ex_q1 = ex; op = 3'(o);
        ir_addr = 9'(ia); pcl_data = 8'(pd); page_sel = 2'(ps); skip_req = sr;
        @(posedge clk);
        modelStep();
        #2;
    endtask

    task automatic idle(input bit fe, input bit ex);
        step(1'b1, fe, ex, 0, 0, 0, 0, 1'b0);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            check("pc", int'(pc), mPc);
            check("goto", int'(goto), mGoto);
            check("skip", int'(skip), mSkip);
            check("level", int'(stack_level), mLvl);
            check("ovf", int'(stack_ovf), mOvf);
            check("unf", int'(stack_unf), mUnf);
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2, 5, 0, 0, 1'b1);
        chkEn = 1'b1;
        check("rst_pc", int'(pc), 'h7FF);
        check("rst_lvl", int'(stack_level), 0);
        check("rst_flags", int'({goto, skip, stack_ovf, stack_unf}), 0);

        idle(1'b1, 1'b0); check("inc_wrap", int'(pc), 'h000);
        idle(1'b1, 1'b0); check("inc1", int'(pc), 'h001);
        idle(1'b1, 1'b0); check("inc2", int'(pc), 'h002);

        step(1'b1, 1'b0, 1'b0, 1, 'h010, 0, 0, 1'b0); idle(1'b0, 1'b1);
        check("goto_pre", int'(pc), 'h010);
        step(1'b1, 1'b0, 1'b0, 1, 'h123, 0, 1, 1'b0);
        check("goto_pc", int'(pc), 'h323);
        check("goto_flags", int'({goto, skip}), 3);
        idle(1'b1, 1'b0); check("goto_noinc", int'(pc), 'h323);
        idle(1'b0, 1'b1); check("ex_clear", int'({goto, skip}), 0);

        step(1'b1, 1'b0, 1'b0, 1, 'h045, 0, 0, 1'b0); idle(1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 2, 'h1AB, 0, 0, 1'b0);
        check("call_pc", int'(pc), 'h0AB);
        check("call_lvl", int'(stack_level), 1);
        idle(1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 1'b0);
        check("ret_pc", int'(pc), 'h045);
        check("ret_lvl", int'(stack_level), 0);
        check("ret_unf", int'(stack_unf), 0);
        idle(1'b0, 1'b1);

        step(1'b1, 1'b0, 1'b0, 1, 'h100, 0, 0, 1'b0); step(1'b1, 1'b0, 1'b0, 2, 0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1, 'h000, 0, 1, 1'b0); step(1'b1, 1'b0, 1'b0, 2, 0, 0, 0, 1'b0);
        check("ovf_pre", int'(stack_ovf), 0);
        step(1'b1, 1'b0, 1'b0, 1, 'h100, 0, 1, 1'b0); step(1'b1, 1'b0, 1'b0, 2, 0, 0, 0, 1'b0);
        check("ovf_set", int'(stack_ovf), 1);
        check("ovf_lvl", int'(stack_level), 2);
        step(1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 1'b0); check("pop1", int'(pc), 'h300);
        step(1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 1'b0); check("pop2", int'(pc), 'h200);
        step(1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 1'b0);
        check("pop_bottom", int'(pc), 'h200);
        check("unf_set", int'(stack_unf), 1);

        idle(1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4, 0, 'h80, 2, 1'b0);
        check("pcl_pc", int'(pc), 'h480);
        check("pcl_flags", int'({goto, skip}), 1);
        idle(1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1'b1);
        check("ex_vs_skipreq", int'(skip), 1);

        step(1'b1, 1'b0, 1'b0, 2, 5, 0, 0, 1'b0); step(1'b1, 1'b0, 1'b0, 2, 6, 0, 0, 1'b0);
        check("pre_rst_lvl", int'(stack_level), 2);
        step(1'b0, 1'b1, 1'b1, 2, 7, 0, 0, 1'b1);
        check("midrst_lvl", int'(stack_level), 0);
        check("midrst_pc", int'(pc), 'h7FF);
        check("midrst_flags", int'({goto, skip, stack_ovf, stack_unf}), 0);

        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 79) != 0), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0));
        end

        chkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program-counter and hardware-return-stack unit for the PIC16C5x core family. It replaces the fixed 9-bit PC with a configurable PC width plus STATUS page-select bits, and adds an internal circular return stack of configurable depth. It sits between the instruction decoder/execute sequencer, which issues per-quarter strobes and decoded operations, and program-memory addressing. It also drives the goto/skip pipeline-flush flags to the fetch stage.

Parameters:
PC_WIDTH, 11, program counter width; legal range 9..13 (PIC16C54 = 9, PIC16C57 = 11).
STACK_DEPTH, 2, number of return-stack entries; legal range 1..8.
RESET_VECTOR, {PC_WIDTH{1'b1}}, PC value loaded at reset (last program word).
PAGE_BITS, PC_WIDTH-9, derived localparam (not overridable); width of page_sel.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
fe_q1  in  1  fetch-Q1 strobe; increments PC
ex_q1  in  1  execute-Q1 strobe; clears goto/skip
op  in  3  execute-Q4 operation: NONE=0, GOTO=1, CALL=2, RETLW=3, PCL_WR=4 (others = NONE)
ir_addr  in  9  IR[8:0] literal address
pcl_data  in  8  data written to PCL
page_sel  in  max(PAGE_BITS,1)  STATUS PA bits; ignored when PAGE_BITS=0
skip_req  in  1  conditional-skip result from DECFSZ/INCFSZ/BTFSx at Q4
pc  out  PC_WIDTH  current program counter
goto  out  1  flush flag: next fetch is a branch target, suppresses increment
skip  out  1  flush flag: instruction being fetched is discarded
stack_level  out  4  number of valid stack entries, 0..STACK_DEPTH
stack_ovf  out  1  sticky: push attempted while full
stack_unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_VECTOR, goto=0, skip=0, all stack entries=0, stack_level=0, stack_ovf=0, stack_unf=0. All inputs ignored during that cycle.
- Increment: fe_q1=1 and goto=0 -> pc <= pc+1, modulo 2^PC_WIDTH (0x7FF wraps to 0x000).
- Flag clear: ex_q1=1 -> goto<=0, skip<=0 (lower priority than the set rules below).
- GOTO: pc <= {page_sel, ir_addr[8:0]}; goto<=1; skip<=1.
- CALL: push the current pc register value, which is already the return address; pc <= {page_sel, 1'b0, ir_addr[7:0]}; goto<=1; skip<=1.
- RETLW: pop; pc <= top entry; goto<=1; skip<=1.
- PCL_WR: pc <= {page_sel, 1'b0, pcl_data}; skip<=1; goto unchanged.
- skip_req=1: skip<=1. ORs with any op.
- When PAGE_BITS=0, the page field is omitted from every concatenation.
- Priority within one cycle, highest first:
  - PC: op write > increment.
  - skip/goto: any set > ex_q1 clear.
- Stack is a shift register, entry 0 = top:
  - push: e[i] <= e[i-1], e[0] <= pc. The oldest entry is lost when full.
  - pop: e[i] <= e[i+1]; the bottom entry is retained (silicon-compatible).
- stack_level increments on push and saturates at STACK_DEPTH. It decrements on pop and saturates at 0.
- Push at level==STACK_DEPTH -> stack_ovf<=1. Pop at level==0 -> stack_unf<=1 and pc still loads e[0]. Sticky flags clear only on reset.
- CALL, RETLW and PCL_WR are mutually exclusive by op encoding.
- No combinational paths from inputs to outputs; every output is a register.
- Reset mid-CALL: the reset wins and the stack stays empty.

Decomposition:
- Op encodings and the PCL address go in the shared define file (add PC_OP_* macros next to the existing EX_/FE_ state macros).
- One sub-module: pc_return_stack (params WIDTH, DEPTH; ports push, pop, din, top, level, ovf, unf). It contains all shift and saturation logic.
- The top level holds the PC register, the flag logic and the operation decode.

Test Plan:
- Reset, then 3 fe_q1 pulses -> pc 0x7FF, 0x000, 0x001, 0x002; goto=skip=0; stack_level=0.
- pc=0x010, page_sel=2'b01, op=GOTO, ir_addr=0x123 -> pc=0x323, goto=skip=1. Next fe_q1 leaves pc at 0x323. ex_q1 clears both flags.
- pc=0x045, op=CALL, ir_addr=0x1AB, page_sel=0 -> pc=0x0AB, level=1. Then op=RETLW -> pc=0x045, level=0, stack_unf=0.
- 3 CALLs from pc 0x100, 0x200, 0x300 (DEPTH=2) -> stack_ovf=1, level=2. Two RETLWs -> pc 0x300 then 0x200. A third RETLW -> pc=0x200 (bottom retained), stack_unf=1.
- Same cycle fe_q1=1, op=PCL_WR, pcl_data=0x80, page_sel=2'b10 -> pc=0x480 (no increment), skip=1, goto unchanged.
- Same cycle ex_q1=1 and skip_req=1 -> skip=1. Assert rst_n=0 mid-sequence with level=2 -> level=0, pc=0x7FF, flags cleared.
